// File: rtl/png_pkg.sv
`default_nettype none
// ============================================================================
// Module      : png_pkg
// Description : Shared PNG encoder definitions: framer states, CRC-32
//               constants, standard chunk type codes and a byte selector.
// Revision    : 1.0 - initial release
// ============================================================================
package png_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_TYPE = 3'd2,
        ST_DATA = 3'd3,
        ST_CRC  = 3'd4
    } state_t;

    localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_RVS = 32'hEDB8_8320;

    localparam logic [31:0] IHDR = 32'h4948_4452;
    localparam logic [31:0] IDAT = 32'h4944_4154;
    localparam logic [31:0] IEND = 32'h4945_4E44;

    // Index 0 selects the most significant byte (first on the wire).
    function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    return word[31:24];
            2'd1:    return word[23:16];
            2'd2:    return word[15:8];
            default: return word[7:0];
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/png_chunk_wrap_if.sv
`default_nettype none
// ============================================================================
// Module      : png_chunk_wrap_if
// Description : Control, data-in and byte-out handshake bundle of the PNG
//               chunk framer. The slave modport is the framer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface png_chunk_wrap_if;

    logic        start_i;
    logic [31:0] len_i;
    logic [31:0] type_i;
    logic        val_i;
    logic [7:0]  dat_i;
    logic        lst_i;
    logic        rdy_o;
    logic        val_o;
    logic [7:0]  dat_o;
    logic        lst_o;
    logic        rdy_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] crc_o;
    logic        err_o;

    modport master (
        output start_i, len_i, type_i, val_i, dat_i, lst_i, rdy_i,
        input  rdy_o, val_o, dat_o, lst_o, busy_o, done_o, crc_o, err_o
    );

    modport slave (
        input  start_i, len_i, type_i, val_i, dat_i, lst_i, rdy_i,
        output rdy_o, val_o, dat_o, lst_o, busy_o, done_o, crc_o, err_o
    );

endinterface
`default_nettype wire

// File: rtl/png_crc32_byte.sv
`default_nettype none
// ============================================================================
// Module      : png_crc32_byte
// Description : Combinational one-byte step of the reflected PNG CRC-32
//               (LSB-first, poly 0xEDB88320, no bit reordering).
// Revision    : 1.0 - initial release
// ============================================================================
module png_crc32_byte
    import png_pkg::*;
(
    input  logic [31:0] crc_cur,
    input  logic [7:0]  byte_in,
    output logic [31:0] crc_nxt
);

    logic [31:0] w_crc;

    always_comb begin
        w_crc = crc_cur ^ {24'd0, byte_in};
        for (int k = 0; k < 8; k++) begin
            w_crc = w_crc[0] ? ((w_crc >> 1) ^ CRC_POLY_RVS) : (w_crc >> 1);
        end
        crc_nxt = w_crc;
    end

endmodule
`default_nettype wire

// File: rtl/png_chunk_wrap.sv
`default_nettype none
// ============================================================================
// Module      : png_chunk_wrap
// Description : PNG chunk framer: emits length, type, data and CRC-32 as a
//               byte stream. Optional length check: PNG_CHUNK_LEN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module png_chunk_wrap
    import png_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    png_chunk_wrap_if.slave  bus
);

    state_t      r_state;
    logic [1:0]  r_idx;
    logic [31:0] r_cnt;
    logic [31:0] r_type;
    logic [31:0] r_crc;
    logic [31:0] r_crc_out;
    logic        r_val;
    logic [7:0]  r_dat;
    logic        r_lst;
    logic        r_busy;
    logic        r_done;

    logic        w_adv;
    logic        w_rdy;
    logic        w_take;
    logic [7:0]  w_crc_byte;
    logic [31:0] w_crc_nxt;

    // The output register may load whenever it is empty or being drained.
    assign w_adv  = !r_val || bus.rdy_i;
    assign w_rdy  = (r_state == ST_DATA) && w_adv;
    assign w_take = bus.val_i && w_rdy;

    assign w_crc_byte = (r_state == ST_DATA) ? bus.dat_i : get_byte(r_type, r_idx);

    png_crc32_byte u_crc (
        .crc_cur (r_crc),
        .byte_in (w_crc_byte),
        .crc_nxt (w_crc_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= 2'd0;
            r_cnt     <= 32'd0;
            r_type    <= 32'd0;
            r_crc     <= CRC_INIT;
            r_crc_out <= 32'd0;
            r_val     <= 1'b0;
            r_dat     <= 8'd0;
            r_lst     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        r_state <= ST_LEN;
                        r_idx   <= 2'd1;
                        r_cnt   <= bus.len_i;
                        r_type  <= bus.type_i;
                        r_crc   <= CRC_INIT;
                        r_val   <= 1'b1;
                        r_dat   <= bus.len_i[31:24];
                        r_lst   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                // r_cnt still holds the declared length while it is sent.
                ST_LEN: begin
                    if (w_adv) begin
                        r_dat <= get_byte(r_cnt, r_idx);
                        r_val <= 1'b1;
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_state <= ST_TYPE;
                        end
                    end
                end
                ST_TYPE: begin
                    if (w_adv) begin
                        r_dat <= get_byte(r_type, r_idx);
                        r_val <= 1'b1;
                        r_crc <= w_crc_nxt;
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            if (r_cnt == 32'd0) begin
                                r_state   <= ST_CRC;
                                r_crc_out <= ~w_crc_nxt;
                            end else begin
                                r_state <= ST_DATA;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (w_take) begin
                        r_dat <= bus.dat_i;
                        r_val <= 1'b1;
                        r_crc <= w_crc_nxt;
                        r_cnt <= r_cnt - 32'd1;
                        if (r_cnt == 32'd1) begin
                            r_state   <= ST_CRC;
                            r_crc_out <= ~w_crc_nxt;
                        end
                    end else if (bus.rdy_i) begin
                        r_val <= 1'b0;
                    end
                end
                // r_lst doubles as "final CRC byte loaded, waiting for accept".
                ST_CRC: begin
                    if (r_lst) begin
                        if (bus.rdy_i) begin
                            r_val   <= 1'b0;
                            r_lst   <= 1'b0;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else if (w_adv) begin
                        r_dat <= get_byte(r_crc_out, r_idx);
                        r_val <= 1'b1;
                        r_lst <= (r_idx == 2'd3);
                        r_idx <= r_idx + 2'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PNG_CHUNK_LEN_CHECK_EN
    logic r_err;

    // lst_i must be high exactly on the final declared byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((r_state == ST_IDLE) && bus.start_i) begin
            r_err <= 1'b0;
        end else if (w_take && (bus.lst_i != (r_cnt == 32'd1))) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err_o = r_err;
`else
    assign bus.err_o = 1'b0;
`endif

    assign bus.rdy_o  = w_rdy;
    assign bus.val_o  = r_val;
    assign bus.dat_o  = r_dat;
    assign bus.lst_o  = r_lst;
    assign bus.busy_o = r_busy;
    assign bus.done_o = r_done;
    assign bus.crc_o  = r_crc_out;

endmodule
`default_nettype wire

// File: tb/tb_png_chunk_wrap.sv
`default_nettype none
// ============================================================================
// Module      : tb_png_chunk_wrap
// Description : Self-checking bench for png_chunk_wrap: vector table plus
//               randomized chunks compared against a byte-level chunk model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_png_chunk_wrap;

    localparam int MODE_TOG   = 1;
    localparam int MODE_GAP   = 2;
    localparam int MODE_START = 4;
    localparam int MODE_RND   = 8;
    localparam int BUDGET     = 2000;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        logic [31:0] len;
        logic [31:0] typ;
        int          mode;
        int          lst_pos;
        bit          fixed;
        bit          known;
        logic [31:0] exp_crc;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    byte_q_t tx_data;

    png_chunk_wrap_if bus ();

    png_chunk_wrap dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] crc32(input byte_q_t b);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            c = c ^ {24'd0, b[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    // Expected wire image: length, type, data, complemented CRC, all MSB first.
    task automatic build_expected(input logic [31:0] len, input logic [31:0] typ,
                                  output byte_q_t exp_q, output logic [31:0] crc);
        byte_q_t covered;
        exp_q = {};
        covered = {};
        for (int i = 3; i >= 0; i--) exp_q.push_back(len[8*i +: 8]);
        for (int i = 3; i >= 0; i--) begin
            exp_q.push_back(typ[8*i +: 8]);
            covered.push_back(typ[8*i +: 8]);
        end
        foreach (tx_data[i]) begin
            exp_q.push_back(tx_data[i]);
            covered.push_back(tx_data[i]);
        end
        crc = crc32(covered);
        for (int i = 3; i >= 0; i--) exp_q.push_back(crc[8*i +: 8]);
    endtask

    task automatic run_chunk(input vec_t v);
        byte_q_t     exp_q;
        byte_q_t     rx;
        logic [31:0] crc_m;
        logic        err_m;
        logic        prev_stall;
        logic [8:0]  prev_out;
        int          di;
        int          cyc;
        bit          seen_done;
        int          total;

        build_expected(v.len, v.typ, exp_q, crc_m);
        total      = exp_q.size();
        rx         = {};
        err_m      = 1'b0;
        prev_stall = 1'b0;
        prev_out   = 9'd0;
        di         = 0;
        seen_done  = 1'b0;

        @(negedge clk);
        bus.start_i = 1'b1;
        bus.len_i   = v.len;
        bus.type_i  = v.typ;
        bus.rdy_i   = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;

        cyc = 0;
        while (!seen_done && cyc < BUDGET) begin
            if ((v.mode & MODE_TOG) != 0)      bus.rdy_i = (cyc % 2) == 0;
            else if ((v.mode & MODE_RND) != 0) bus.rdy_i = 1'($urandom_range(0, 1));
            else                               bus.rdy_i = 1'b1;
            bus.val_i = (di < tx_data.size()) &&
                        (((v.mode & MODE_GAP) == 0) || ($urandom_range(0, 3) != 0));
            bus.dat_i = (di < tx_data.size()) ? tx_data[di] : 8'h00;
            bus.lst_i = (di == v.lst_pos);
            if (((v.mode & MODE_START) != 0) && cyc == 9) begin
                bus.start_i = 1'b1;
                bus.len_i   = 32'h77;
                bus.type_i  = 32'h4948_4452;
            end else begin
                bus.start_i = 1'b0;
            end
            #1;
            if (cyc == 0) chk("first_beat", {23'd0, bus.val_o, bus.dat_o}, {23'd0, 1'b1, v.len[31:24]});
            chk("err_o", {31'd0, bus.err_o}, {31'd0, err_m});
            if (prev_stall) chk("stall_hold", {23'd0, bus.val_o, bus.lst_o, bus.dat_o}, {23'd0, 1'b1, prev_out});
            if (bus.done_o) begin
                seen_done = 1'b1;
                chk("busy_fall", {31'd0, bus.busy_o}, 32'd0);
                if ((v.mode & (MODE_TOG | MODE_GAP | MODE_RND)) == 0)
                    chk("done_latency", cyc, 12 + v.len);
            end
            if (bus.val_o && bus.rdy_i) begin
                chk("beat_byte", {24'd0, bus.dat_o},
                    (rx.size() < total) ? {24'd0, exp_q[rx.size()]} : 32'hDEAD);
                rx.push_back(bus.dat_o);
                chk("beat_lst", {31'd0, bus.lst_o}, {31'd0, rx.size() == total});
            end
            if (bus.val_i && bus.rdy_o) begin
`ifdef PNG_CHUNK_LEN_CHECK_EN
                if (bus.lst_i != (di == int'(v.len) - 1)) err_m = 1'b1;
`endif
                di++;
            end
            prev_stall = bus.val_o && !bus.rdy_i;
            prev_out   = {bus.lst_o, bus.dat_o};
            cyc++;
            if (!seen_done) @(negedge clk);
        end
        bus.val_i   = 1'b0;
        bus.start_i = 1'b0;
        if (!seen_done) chk("done_timeout", 32'd0, 32'd1);
        chk("beat_count", rx.size(), total);
        chk("data_consumed", di, tx_data.size());
        chk("crc_o", bus.crc_o, v.known ? v.exp_crc : crc_m);
        @(negedge clk);
        #1;
        chk("done_pulse", {31'd0, bus.done_o}, 32'd0);
        chk("err_sticky", {31'd0, bus.err_o}, {31'd0, err_m});
    endtask

    task automatic fill_data(input vec_t v);
        tx_data = {};
        if (v.fixed) begin
            tx_data = '{8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        end else begin
            for (int i = 0; i < int'(v.len); i++) tx_data.push_back(8'($urandom_range(0, 255)));
        end
    endtask

    vec_t tbl[9];

    initial begin
        vec_t v;
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.len_i   = 32'd0;
        bus.type_i  = 32'd0;
        bus.val_i   = 1'b0;
        bus.dat_i   = 8'd0;
        bus.lst_i   = 1'b0;
        bus.rdy_i   = 1'b1;

        tbl[0] = '{32'd0,  32'h4945_4E44, 0,                   -1, 1'b0, 1'b1, 32'hAE42_6082};
        tbl[1] = '{32'd5,  32'h3132_3334, 0,                    4, 1'b1, 1'b1, 32'hCBF4_3926};
        tbl[2] = '{32'd5,  32'h3132_3334, MODE_TOG | MODE_GAP,  4, 1'b1, 1'b1, 32'hCBF4_3926};
        tbl[3] = '{32'd5,  32'h3132_3334, MODE_START,           4, 1'b1, 1'b1, 32'hCBF4_3926};
        tbl[4] = '{32'd13, 32'h4948_4452, MODE_RND | MODE_GAP, 12, 1'b0, 1'b0, 32'd0};
        tbl[5] = '{32'd40, 32'h4944_4154, MODE_GAP,            39, 1'b0, 1'b0, 32'd0};
        tbl[6] = '{32'd3,  32'h4944_4154, 0,                    1, 1'b0, 1'b0, 32'd0};
        tbl[7] = '{32'd4,  32'h4944_4154, MODE_GAP,            -1, 1'b0, 1'b0, 32'd0};
        tbl[8] = '{32'd7,  32'h4944_4154, MODE_RND,             6, 1'b0, 1'b0, 32'd0};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_outputs", {24'd0, bus.val_o, bus.lst_o, bus.rdy_o, bus.busy_o, bus.done_o,
                            bus.err_o, 2'd0}, 32'd0);
        chk("rst_dat", {24'd0, bus.dat_o}, 32'd0);
        chk("rst_crc", bus.crc_o, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            fill_data(tbl[i]);
            run_chunk(tbl[i]);
        end

        // Abort mid-TYPE with reset, then a clean IEND.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.len_i   = 32'd5;
        bus.type_i  = 32'h3132_3334;
        bus.rdy_i   = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_val", {31'd0, bus.val_o}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy_o}, 32'd0);
        @(negedge clk);
        #1;
        chk("abort_hold", {24'd0, bus.val_o, bus.busy_o, bus.lst_o, bus.done_o, 4'd0}, 32'd0);
        rst = 1'b0;
        fill_data(tbl[0]);
        run_chunk(tbl[0]);

        for (int n = 0; n < 10; n++) begin
            v.len     = 32'($urandom_range(0, 24));
            v.typ     = 32'h4944_4154;
            v.mode    = int'($urandom_range(0, 15));
            v.lst_pos = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 24)) : int'(v.len) - 1;
            v.fixed   = 1'b0;
            v.known   = 1'b0;
            v.exp_crc = 32'd0;
            fill_data(v);
            run_chunk(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
